lottery_draw_sequencer: RTL and testbench

Consumes the free-running 16-bit `random_number` stream from the upstream number generator and produces a sequence of DRAW_COUNT unique values in the range 1..RANGE. Each raw sample is reduced modulo RANGE by a bit-serial remainder unit, then checked against a bitmap of values already drawn; duplicates are discarded and resampled. Accepted draws leave through a valid/ready handshake to the downstream display/scoring logic.

---
 rtl/lottery_draw_sequencer_if.sv | 23 ++
 rtl/lottery_draw_sequencer.sv | 175 +++++++++++++++++
 tb/tb_lottery_draw_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lottery_draw_sequencer_if.sv
// Draw output channel of lottery_draw_sequencer: one accepted draw per transfer.
// A draw transfers on a rising clk edge where draw_valid and draw_ready are both 1; once
// raised, draw_valid stays high and draw_value/draw_index stay stable until that edge.
interface lottery_draw_sequencer_if;
   logic       draw_valid;
   logic       draw_ready;
   logic [7:0] draw_value;
   logic [3:0] draw_index;

   modport master (
      output draw_valid,
      output draw_value,
      output draw_index,
      input  draw_ready
   );

   modport slave (
      input  draw_valid,
      input  draw_value,
      input  draw_index,
      output draw_ready
   );
endinterface

// File: rtl/lottery_draw_sequencer.sv
// Draws DRAW_COUNT unique values in 1..RANGE from a free-running 16-bit random stream,
// using a bit-serial modulo reduction and a drawn-value bitmap to reject duplicates.
module lottery_draw_sequencer #(
   parameter int DRAW_COUNT = 6,
   parameter int RANGE      = 49
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] random_number,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state_dbg,
   lottery_draw_sequencer_if.master draw
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      REDUCE = 3'd2,
      CHECK  = 3'd3,
      OUTPUT = 3'd4
   } state_t;

   localparam logic [8:0] RANGE_9    = 9'(RANGE);
   localparam logic [3:0] LAST_INDEX = 4'(DRAW_COUNT - 1);

   state_t           state, state_nxt;
   logic [15:0]      sample_q, sample_nxt;
   logic [3:0]       bit_cnt_q, bit_cnt_nxt;
   logic [8:0]       rem_q, rem_nxt;
   logic [RANGE-1:0] bitmap_q, bitmap_nxt;
   logic [3:0]       count_q, count_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;
   logic             valid_q, valid_nxt;
   logic [7:0]       value_q, value_nxt;
   logic [3:0]       index_q, index_nxt;

   logic [8:0]       shifted;
   logic [8:0]       reduced;
   logic [RANGE-1:0] rem_onehot;
   logic             already_drawn;

   // One restoring-division step: bring in the next sample bit, subtract RANGE if it fits.
   always_comb begin
      shifted = {rem_q[7:0], sample_q[15]};
      reduced = (shifted >= RANGE_9) ? (shifted - RANGE_9) : shifted;
   end

   always_comb begin
      rem_onehot = '0;
      for (int i = 0; i < RANGE; i++) begin
         rem_onehot[i] = (rem_q == 9'(i));
      end
      already_drawn = |(rem_onehot & bitmap_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      sample_nxt  = sample_q;
      bit_cnt_nxt = bit_cnt_q;
      rem_nxt     = rem_q;
      bitmap_nxt  = bitmap_q;
      count_nxt   = count_q;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
      valid_nxt   = valid_q;
      value_nxt   = value_q;
      index_nxt   = index_q;

      case (state)
         IDLE: begin
            if (start) begin
               sample_nxt  = random_number;
               bit_cnt_nxt = '0;
               rem_nxt     = '0;
               bitmap_nxt  = '0;
               count_nxt   = '0;
               busy_nxt    = 1'b1;
               state_nxt   = REDUCE;
            end
         end

         SAMPLE: begin
            sample_nxt  = random_number;
            bit_cnt_nxt = '0;
            rem_nxt     = '0;
            state_nxt   = REDUCE;
         end

         REDUCE: begin
            rem_nxt     = reduced;
            sample_nxt  = {sample_q[14:0], 1'b0};
            bit_cnt_nxt = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
               state_nxt = CHECK;
            end
         end

         CHECK: begin
            if (already_drawn) begin
               state_nxt = SAMPLE;
            end else begin
               bitmap_nxt = bitmap_q | rem_onehot;
               value_nxt  = rem_q[7:0] + 8'd1;
               index_nxt  = count_q;
               valid_nxt  = 1'b1;
               state_nxt  = OUTPUT;
            end
         end

         OUTPUT: begin
            // The draw is held until accepted; start has no effect here.
            if (draw.draw_ready) begin
               valid_nxt = 1'b0;
               if (count_q == LAST_INDEX) begin
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  count_nxt = count_q + 4'd1;
                  state_nxt = SAMPLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_q  <= '0;
         bit_cnt_q <= '0;
         rem_q     <= '0;
         bitmap_q  <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         value_q   <= '0;
         index_q   <= '0;
      end else begin
         sample_q  <= sample_nxt;
         bit_cnt_q <= bit_cnt_nxt;
         rem_q     <= rem_nxt;
         bitmap_q  <= bitmap_nxt;
         count_q   <= count_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         valid_q   <= valid_nxt;
         value_q   <= value_nxt;
         index_q   <= index_nxt;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign state_dbg       = state;
   assign draw.draw_valid = valid_q;
   assign draw.draw_value = value_q;
   assign draw.draw_index = index_q;

endmodule

// File: tb/tb_lottery_draw_sequencer.sv
// Directed testbench for lottery_draw_sequencer (RANGE=49, DRAW_COUNT=6).
// Each scenario task drives its stimulus and compares against hand-computed values.
module tb_lottery_draw_sequencer;

   localparam int RANGE      = 49;
   localparam int DRAW_COUNT = 6;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_REDUCE = 3'd2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] random_number;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];

   lottery_draw_sequencer_if draw_if ();

   lottery_draw_sequencer #(
      .DRAW_COUNT(DRAW_COUNT),
      .RANGE     (RANGE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .random_number(random_number),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .state_dbg    (state_dbg),
      .draw         (draw_if.master)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All driving and sampling happens 1 time unit after a rising edge.
   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      draw_if.draw_ready = 1'b0;
      random_number = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int cycles);
      cycles = 0;
      while (draw_if.draw_valid !== 1'b1 && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (draw_if.draw_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", draw_if.draw_valid); end
      checks++; if (draw_if.draw_value !== 8'd0) begin failures++; $display("FAIL reset_value: got %0d expected 0", draw_if.draw_value); end
      checks++; if (draw_if.draw_index !== 4'd0) begin failures++; $display("FAIL reset_index: got %0d expected 0", draw_if.draw_index); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
   endtask

   task automatic test_basic_draw();
      int lat;
      do_reset();
      random_number = 16'd100;
      draw_if.draw_ready = 1'b1;
      pulse_start();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
      checks++; if (state_dbg !== ST_REDUCE) begin failures++; $display("FAIL basic_state: got %0d expected %0d", state_dbg, ST_REDUCE); end
      wait_valid(40, lat);
      checks++; if (lat != 17) begin failures++; $display("FAIL basic_latency: got %0d expected 17", lat); end
      checks++; if (draw_if.draw_value !== 8'd3) begin failures++; $display("FAIL basic_value: got %0d expected 3", draw_if.draw_value); end
      checks++; if (draw_if.draw_index !== 4'd0) begin failures++; $display("FAIL basic_index: got %0d expected 0", draw_if.draw_index); end
   endtask

   task automatic test_modulo_boundaries();
      logic [15:0] mod_in  [4] = '{16'd0, 16'd48, 16'd49, 16'd65535};
      logic [7:0]  mod_exp [4] = '{8'd1, 8'd49, 8'd1, 8'd23};
      int lat;
      for (int i = 0; i < 4; i++) begin
         do_reset();
         random_number = mod_in[i];
         pulse_start();
         wait_valid(40, lat);
         checks++;
         if (draw_if.draw_valid !== 1'b1 || draw_if.draw_value !== mod_exp[i]) begin
            failures++;
            $display("FAIL modulo_%0d: got valid=%b value=%0d expected valid=1 value=%0d",
                     mod_in[i], draw_if.draw_valid, draw_if.draw_value, mod_exp[i]);
         end
      end
   endtask

   task automatic test_duplicate();
      int lat;
      int seen_valid = 0;
      int busy_low   = 0;
      do_reset();
      random_number = 16'd100;
      draw_if.draw_ready = 1'b1;
      pulse_start();
      wait_valid(40, lat);
      checks++; if (draw_if.draw_value !== 8'd3) begin failures++; $display("FAIL dup_first_value: got %0d expected 3", draw_if.draw_value); end
      @(posedge clk); #1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (draw_if.draw_valid === 1'b1) seen_valid++;
         if (busy !== 1'b1) busy_low++;
      end
      checks++; if (seen_valid != 0) begin failures++; $display("FAIL dup_no_valid: got %0d valid cycles expected 0", seen_valid); end
      checks++; if (busy_low != 0) begin failures++; $display("FAIL dup_busy: got %0d busy-low cycles expected 0", busy_low); end
      random_number = 16'd200;
      wait_valid(60, lat);
      checks++; if (draw_if.draw_value !== 8'd5) begin failures++; $display("FAIL dup_second_value: got %0d expected 5", draw_if.draw_value); end
      checks++; if (draw_if.draw_index !== 4'd1) begin failures++; $display("FAIL dup_second_index: got %0d expected 1", draw_if.draw_index); end
   endtask

   task automatic test_backpressure();
      int lat;
      int unstable = 0;
      do_reset();
      random_number = 16'd100;
      draw_if.draw_ready = 1'b0;
      pulse_start();
      wait_valid(40, lat);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (draw_if.draw_valid !== 1'b1 || draw_if.draw_value !== 8'd3 || draw_if.draw_index !== 4'd0)
            unstable++;
      end
      checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
      draw_if.draw_ready = 1'b1;
      random_number = 16'd200;
      @(posedge clk); #1;
      draw_if.draw_ready = 1'b0;
      checks++; if (draw_if.draw_valid !== 1'b0) begin failures++; $display("FAIL bp_accept: got valid=%b expected 0", draw_if.draw_valid); end
      wait_valid(40, lat);
      checks++; if (lat != 18) begin failures++; $display("FAIL bp_next_latency: got %0d expected 18", lat); end
      checks++; if (draw_if.draw_value !== 8'd5) begin failures++; $display("FAIL bp_next_value: got %0d expected 5", draw_if.draw_value); end
      checks++; if (draw_if.draw_index !== 4'd1) begin failures++; $display("FAIL bp_next_index: got %0d expected 1", draw_if.draw_index); end
   endtask

   task automatic test_full_sequence();
      logic [RANGE:0] seen;
      logic [3:0]     exp_index;
      logic [7:0]     first_value = '0;
      int draws = 0;
      int cycles = 0;
      int early_done = 0;
      int busy_drop = 0;
      int lat;
      do_reset();
      seen = '0;
      exp_q.delete();
      for (int i = 0; i < DRAW_COUNT; i++) exp_q.push_back(4'(i));
      random_number = 16'd7;
      draw_if.draw_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      while (draws < DRAW_COUNT && cycles < 3000) begin
         if (done !== 1'b0) early_done++;
         if (busy !== 1'b1) busy_drop++;
         if (draw_if.draw_valid === 1'b1) begin
            exp_index = exp_q.pop_front();
            checks++; if (draw_if.draw_index !== exp_index) begin failures++; $display("FAIL full_index: got %0d expected %0d", draw_if.draw_index, exp_index); end
            checks++;
            if (draw_if.draw_value < 8'd1 || draw_if.draw_value > 8'(RANGE) || seen[draw_if.draw_value[5:0]]) begin
               failures++;
               $display("FAIL full_unique: got value %0d expected unused value in 1..%0d", draw_if.draw_value, RANGE);
            end else begin
               seen[draw_if.draw_value[5:0]] = 1'b1;
            end
            if (draws == 0) first_value = draw_if.draw_value;
            draws++;
         end
         if (draws < DRAW_COUNT) begin
            @(posedge clk); #1;
            random_number = random_number + 16'd1;
            cycles++;
         end
      end
      checks++; if (draws != DRAW_COUNT) begin failures++; $display("FAIL full_count: got %0d draws expected %0d", draws, DRAW_COUNT); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_scoreboard: got %0d pending expected 0", exp_q.size()); end
      checks++; if (early_done != 0) begin failures++; $display("FAIL full_early_done: got %0d cycles expected 0", early_done); end
      checks++; if (busy_drop != 0) begin failures++; $display("FAIL full_busy: got %0d busy-low cycles expected 0", busy_drop); end
      // Next sample would be a duplicate of the first draw unless the bitmap is cleared.
      random_number = 16'(first_value) - 16'd1;
      @(posedge clk); #1;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done: got %b expected 1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_end: got %b expected 0", busy); end
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_width: got %b expected 0", done); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_restart: got busy=%b expected 1", busy); end
      wait_valid(40, lat);
      checks++; if (lat != 17) begin failures++; $display("FAIL full_restart_latency: got %0d expected 17", lat); end
      checks++; if (draw_if.draw_value !== first_value) begin failures++; $display("FAIL full_bitmap_clear: got %0d expected %0d", draw_if.draw_value, first_value); end
      checks++; if (draw_if.draw_index !== 4'd0) begin failures++; $display("FAIL full_restart_index: got %0d expected 0", draw_if.draw_index); end
   endtask

   task automatic test_reset_mid_reduce();
      int lat;
      int stray = 0;
      do_reset();
      random_number = 16'd100;
      draw_if.draw_ready = 1'b1;
      pulse_start();
      wait_valid(40, lat);
      @(posedge clk); #1;
      random_number = 16'd200;
      repeat (6) @(posedge clk);
      #1;
      checks++; if (state_dbg !== ST_REDUCE) begin failures++; $display("FAIL rst_pre_state: got %0d expected %0d", state_dbg, ST_REDUCE); end
      checks++; if (draw_if.draw_value !== 8'd3) begin failures++; $display("FAIL rst_pre_value: got %0d expected 3", draw_if.draw_value); end
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
      checks++; if (draw_if.draw_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid: got %b expected 0", draw_if.draw_valid); end
      checks++; if (draw_if.draw_value !== 8'd0) begin failures++; $display("FAIL rst_async_value: got %0d expected 0", draw_if.draw_value); end
      checks++; if (draw_if.draw_index !== 4'd0) begin failures++; $display("FAIL rst_async_index: got %0d expected 0", draw_if.draw_index); end
      checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL rst_async_state: got %0d expected %0d", state_dbg, ST_IDLE); end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (draw_if.draw_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL rst_quiet: got %0d active cycles expected 0", stray); end
      pulse_start();
      wait_valid(40, lat);
      checks++; if (lat != 17) begin failures++; $display("FAIL rst_restart_latency: got %0d expected 17", lat); end
      checks++; if (draw_if.draw_value !== 8'd5) begin failures++; $display("FAIL rst_restart_value: got %0d expected 5", draw_if.draw_value); end
      checks++; if (draw_if.draw_index !== 4'd0) begin failures++; $display("FAIL rst_restart_index: got %0d expected 0", draw_if.draw_index); end
   endtask

   initial begin
      test_reset();
      test_basic_draw();
      test_modulo_boundaries();
      test_duplicate();
      test_backpressure();
      test_full_sequence();
      test_reset_mid_reduce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
